// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int unsigned UART_DATA_W   = 8;
  localparam logic        TX_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_end_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // bit_end is registered from the next count so it lines up with cnt_q == LAST
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      bit_end_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_end_q <= (cnt_d == LAST);
    end
  end

  assign bit_end_o = bit_end_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from a registered-output FIFO and frames them
// as start, 8 data bits LSB first, optional parity, and one or two stop bits.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_en_i,
  input  logic                   fifo_empty_i,
  input  logic [UART_DATA_W-1:0] fifo_data_i,
  output logic                   fifo_rd_en_o,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam logic       ODD_BIT   = (PARITY_ODD != 0);
  localparam logic       USE_PAR   = (PARITY_EN != 0);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_W - 1);

  tx_state_t              state_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic [2:0]             bit_cnt_q;
  logic                   stop_cnt_q;
  logic                   parity_q;
  logic                   tx_q;
  logic                   busy_q;
  logic                   rd_en_q;
  logic                   bit_end;
  logic                   timer_clear;
  logic                   start_ok;

  assign start_ok    = tx_en_i && !fifo_empty_i;
  assign timer_clear = (state_q == IDLE) || (state_q == READ) || (state_q == LOAD);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear),
    .bit_end_o(bit_end)
  );

  // Frame sequencer; outputs are updated on the same edge as the state they belong to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= TX_IDLE_LEVEL;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= READ;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        READ: state_q <= LOAD;
        LOAD: begin
          shift_q  <= fifo_data_i;
          parity_q <= (^fifo_data_i) ^ ODD_BIT;
          tx_q     <= ~TX_IDLE_LEVEL;
          state_q  <= START;
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= USE_PAR ? PARITY : STOP;
              tx_q    <= USE_PAR ? parity_q : TX_IDLE_LEVEL;
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx_q    <= TX_IDLE_LEVEL;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_cnt_q == LAST_STOP) begin
              stop_cnt_q <= 1'b0;
              if (start_ok) begin
                state_q <= READ;
                rd_en_q <= 1'b1;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en_o = rd_en_q;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = (state_q == STOP) && bit_end && (stop_cnt_q == LAST_STOP);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three frame formats fed the same byte stream and
// checked every cycle against a frame-timeline model.
module tb_fifo_uart_tx;

  localparam int C = 4;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic tx_en;

  logic [7:0] mem [256];
  int         wr_ptr;
  int         rd_ptr [N];
  logic [7:0] fifo_data [N];
  logic [N-1:0] fifo_empty, rd_en, tx, busy, done;

  for (genvar g = 0; g < N; g++) begin : g_empty
    assign fifo_empty[g] = (wr_ptr == rd_ptr[g]);
  end

  fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tx_en_i(tx_en), .fifo_empty_i(fifo_empty[0]),
    .fifo_data_i(fifo_data[0]), .fifo_rd_en_o(rd_en[0]), .tx_o(tx[0]),
    .busy_o(busy[0]), .frame_done_o(done[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tx_en_i(tx_en), .fifo_empty_i(fifo_empty[1]),
    .fifo_data_i(fifo_data[1]), .fifo_rd_en_o(rd_en[1]), .tx_o(tx[1]),
    .busy_o(busy[1]), .frame_done_o(done[1]));

  fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .tx_en_i(tx_en), .fifo_empty_i(fifo_empty[2]),
    .fifo_data_i(fifo_data[2]), .fifo_rd_en_o(rd_en[2]), .tx_o(tx[2]),
    .busy_o(busy[2]), .frame_done_o(done[2]));

  function automatic int pe_of(input int g);
    return (g != 0) ? 1 : 0;
  endfunction

  function automatic logic po_of(input int g);
    return (g == 2);
  endfunction

  function automatic int sb_of(input int g);
    return (g == 1) ? 2 : 1;
  endfunction

  function automatic int nbits(input int g);
    return 9 + pe_of(g) + sb_of(g);
  endfunction

  // READ + LOAD, then every serial bit held C cycles
  function automatic int flen(input int g);
    return 2 + nbits(g) * C;
  endfunction

  function automatic logic exp_bit(input logic [7:0] b, input int idx, input int g);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && pe_of(g) == 1) return (^b) ^ po_of(g);
    return 1'b1;
  endfunction

  // Hand-derived line images of byte 0xA5, bit 0 = start bit
  function automatic logic [11:0] lit_a5(input int g);
    case (g)
      0:       return 12'h34A;
      1:       return 12'hD4A;
      default: return 12'h74A;
    endcase
  endfunction

  int checks;
  int errors;
  bit do_final;
  bit final_done;

  bit          m_act  [N];
  int          m_t    [N];
  int          m_rd   [N];
  logic [7:0]  m_byte [N];
  logic [11:0] cap    [N];
  int          rd_seen   [N];
  int          done_seen [N];

  task automatic check(input string name, input int g, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, g, $time, act, exp);
    end
  endtask

  // Bench FIFO, model and comparison in one process
  always @(posedge clk or negedge rst) begin : cmp
    logic e_rd, e_tx, e_busy, e_done;
    int   t;
    for (int g = 0; g < N; g++) begin
      if (!rst) begin
        m_act[g] = 1'b0;
      end else begin
        if (rd_en[g]) begin
          fifo_data[g] <= mem[8'(rd_ptr[g])];
          rd_ptr[g]    <= rd_ptr[g] + 1;
          rd_seen[g]++;
        end
        if (m_act[g] && m_t[g] != flen(g) - 1) begin
          m_t[g]++;
        end else begin
          m_act[g] = 1'b0;
          if (tx_en && m_rd[g] != wr_ptr) begin
            m_act[g]  = 1'b1;
            m_t[g]    = 0;
            m_byte[g] = mem[8'(m_rd[g])];
            m_rd[g]++;
            cap[g]    = '0;
          end
        end
      end
    end
    #1;
    for (int g = 0; g < N; g++) begin
      t = m_t[g];
      if (m_act[g]) begin
        e_rd   = (t == 0);
        e_tx   = (t < 2) ? 1'b1 : exp_bit(m_byte[g], (t - 2) / C, g);
        e_busy = 1'b1;
        e_done = (t == flen(g) - 1);
      end else begin
        e_rd = 1'b0; e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end
      check("fifo_rd_en", g, 12'(rd_en[g]), 12'(e_rd));
      check("tx", g, 12'(tx[g]), 12'(e_tx));
      check("busy", g, 12'(busy[g]), 12'(e_busy));
      check("frame_done", g, 12'(done[g]), 12'(e_done));
      if (done[g]) done_seen[g]++;
      if (m_act[g] && t >= 2 && (t - 2) % C == C / 2) cap[g][(t - 2) / C] = tx[g];
      if (m_act[g] && e_done && m_byte[g] == 8'hA5) check("a5_line_image", g, cap[g], lit_a5(g));
    end
    if (do_final && !final_done) begin
      for (int g = 0; g < N; g++) begin
        check("read_pulse_count", g, 12'(rd_seen[g]), 12'd9);
        check("frame_done_count", g, 12'(done_seen[g]), 12'd8);
      end
      final_done = 1'b1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[8'(wr_ptr)] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    rst   = 1'b0;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    tx_en = 1'b1;
    repeat (100) @(negedge clk);

    push(8'hA5);
    repeat (70) @(negedge clk);

    push(8'h01); push(8'h80); push(8'hFF); push(8'h00);
    repeat (230) @(negedge clk);

    // tx_en dropped during D3 of 0x3C with 0x55 still queued
    push(8'h3C); push(8'h55);
    repeat (21) @(negedge clk);
    tx_en = 1'b0;
    repeat (80) @(negedge clk);
    tx_en = 1'b1;
    repeat (70) @(negedge clk);

    // reset during D5 of 0x96; 0x69 must follow with a fresh read
    push(8'h96); push(8'h69);
    repeat (28) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (70) @(negedge clk);

    do_final = 1'b1;
    repeat (3) @(negedge clk);
    if (!final_done) $display("FAIL final_checks: got not-run expected run");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

UART transmitter that drains the 8-bit, 4-deep byte FIFO and serialises each byte onto a single-wire asynchronous line. It sits directly downstream of the FIFO. It drives the FIFO's read-enable, monitors its empty flag, and captures its registered read-data output. Frames are 8N1 by default; parity and a second stop bit are parameter options.

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0: 1 inserts a parity bit after D7.
- PARITY_ODD, 0: with PARITY_EN=1, 1 selects odd parity and 0 selects even.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- tx_en  in  1  permits a new frame to start; sampled only in IDLE and LAST-stop-bit decisions.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO read data, valid the cycle after a read.
- fifo_rd_en  out  1  FIFO read strobe; pulse of exactly 1 cycle.
- tx  out  1  serial line, idle high.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  1-cycle pulse in the final cycle of the last stop bit.

## Operation
- Reset values: tx=1, busy=0, fifo_rd_en=0, frame_done=0, state=IDLE, bit counter=0, cycle counter=0, shift register=0x00.
- States: IDLE, READ, LOAD, START, DATA, PARITY, STOP.
- IDLE: if tx_en=1 and fifo_empty=0, go to READ. Otherwise stay in IDLE.
- READ: fifo_rd_en=1 for exactly this one cycle; next state is LOAD. The strobe is a registered/Moore output and never lasts longer than one cycle, so one frame never reads twice.
- LOAD: capture fifo_data into the shift register and compute parity (XOR of the 8 bits, inverted when PARITY_ODD=1); next state is START.
- START: tx=0.
- DATA: tx=shift[0], LSB first; after each bit, shift right and increment the bit counter (3 bits). After bit 7, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx=computed parity bit.
- STOP: tx=1 for STOP_BITS bit periods.
- End of the last stop bit: if tx_en=1 and fifo_empty=0, go directly to READ; else go to IDLE.
- Every bit period (start, data, parity, stop) lasts exactly CLKS_PER_BIT cycles. The cycle counter has width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, and clears at every bit boundary.
- tx is 1 in IDLE, READ and LOAD. tx is registered, so there are no glitches.
- Deasserting tx_en mid-frame has no effect on the frame in progress; the block finishes the frame, then idles.
- fifo_empty is ignored outside IDLE and the last-stop-bit decision.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). The byte in flight is discarded. The FIFO is not re-read.

## Timing
- Read-to-data latency: fifo_rd_en is high in cycle N, and fifo_data is sampled at the end of cycle N+1 (LOAD).
- The start bit begins in cycle N+2.
- Start latency from IDLE with data available: 1 cycle to READ, then the start bit begins 3 cycles after the IDLE decision.
- Frame length = (1 + 8 + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames have exactly 2 idle-high cycles (READ, LOAD) between the last stop bit and the next start bit.
- frame_done coincides with the last cycle of the final stop bit.
- busy rises in the READ cycle and falls on entry to IDLE.

## Structure
- Shared package fifo_uart_pkg contains:
  - tx_state_t enum (IDLE, READ, LOAD, START, DATA, PARITY, STOP).
  - TX_IDLE_LEVEL = 1'b1.
  - UART_DATA_W = 8.
- One sub-module, uart_bit_timer:
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clk, rst, clear.
  - Output: bit_end, a 1-cycle pulse in the last cycle of each bit period.
- The FSM, shift register and parity logic live in fifo_uart_tx.

## Test plan
- Reset with CLKS_PER_BIT=4 and fifo_empty=1 → tx=1, busy=0, fifo_rd_en never asserted over 100 cycles.
- Single byte 0xA5, 8N1, CLKS_PER_BIT=4 → one fifo_rd_en pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; frame_done pulses once; busy falls 40 cycles after the start bit begins.
- 0xA5 with PARITY_EN=1 → parity bit 0 when PARITY_ODD=0 and 1 when PARITY_ODD=1; with STOP_BITS=2, two 4-cycle stop bits; frame length 48 cycles.
- Four queued bytes 0x01, 0x80, 0xFF, 0x00 → exactly 4 read pulses, frames in FIFO order, exactly 2 idle-high cycles between frames, then IDLE with fifo_empty=1.
- tx_en dropped during D3 of byte 0x3C while the FIFO still holds data → the frame completes intact, no further fifo_rd_en, block returns to IDLE; re-asserting tx_en starts the next byte.
- rst pulsed low during D5 → tx=1 and busy=0 asynchronously; after release with data available, a clean new frame starts with a fresh read.
